// File: rtl/ise_sort_engine_param.sv
// ise_sort_engine_param
// Labels each incoming image with its dominant colour class and an intensity
// key. When a frame is complete it sorts the entries and streams out the
// ordered image indices under ready/valid flow control.
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous active-low reset
//   in_valid         pixel_in / image_in_index valid
//   image_in_index   index of the image that owns pixel_in
//   pixel_in         {R,G,B} pixel, R in the MSBs
//   busy             1 = pixels are not accepted (SORT / OUTPUT)
//   out_valid        a sorted entry is presented
//   out_ready        consumer accepts the presented entry
//   color_index      class of the presented entry (0 red, 1 green, 2 blue)
//   image_out_index  image index of the presented entry
module ise_sort_engine_param #(
    parameter int unsigned IMAGE_NUM   = 32,
    parameter int unsigned PIX_PER_IMG = 16384,
    parameter int unsigned CH_W        = 8,
    parameter int unsigned SORT_DESC   = 0,
    localparam int unsigned IDX_W      = $clog2(IMAGE_NUM),
    localparam int unsigned CNT_W      = $clog2(PIX_PER_IMG + 1),
    localparam int unsigned KEY_W      = CH_W + CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [IDX_W-1:0]   image_in_index,
    input  logic [3*CH_W-1:0]  pixel_in,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         color_index,
    output logic [IDX_W-1:0]   image_out_index
);

    typedef struct packed {
        logic [1:0]       cls;
        logic [KEY_W-1:0] key;
        logic [IDX_W-1:0] idx;
    } entry_t;

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_SORT    = 2'd1,
        S_OUTPUT  = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IMG = IDX_W'(IMAGE_NUM - 1);
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIX_PER_IMG - 1);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_pix_cnt;
    logic [CNT_W-1:0] r_vote_r, r_vote_g, r_vote_b;
    logic [CNT_W-1:0] w_vote_r, w_vote_g, w_vote_b;
    logic [KEY_W-1:0] r_sum_r, r_sum_g, r_sum_b;
    logic [KEY_W-1:0] w_sum_r, w_sum_g, w_sum_b;
    logic [IDX_W-1:0] r_img_cnt, r_pass_cnt, r_out_ptr, w_out_ptr_inc;
    logic [CH_W-1:0]  w_ch_r, w_ch_g, w_ch_b;
    entry_t           r_tbl  [IMAGE_NUM];
    entry_t           w_pass [IMAGE_NUM];
    entry_t           w_entry;
    logic             w_accept, w_sort_step, w_load, w_hs, w_done;
    logic             w_last_pix, w_last_img;

    assign w_ch_r        = pixel_in[3*CH_W-1 -: CH_W];
    assign w_ch_g        = pixel_in[2*CH_W-1 -: CH_W];
    assign w_ch_b        = pixel_in[CH_W-1:0];
    assign w_last_pix    = (r_pix_cnt == LAST_PIX);
    assign w_last_img    = (r_img_cnt == LAST_IMG);
    assign w_done        = w_hs & (r_out_ptr == LAST_IMG);
    assign w_out_ptr_inc = r_out_ptr + IDX_W'(1);

    // True when a must be placed after b: class asc, key asc/desc, index asc.
    function automatic logic entry_gt(input entry_t a, input entry_t b);
        logic gt;
        if (a.cls != b.cls) begin
            gt = (a.cls > b.cls);
        end else if (a.key != b.key) begin
            gt = (SORT_DESC != 0) ? (a.key < b.key) : (a.key > b.key);
        end else begin
            gt = (a.idx > b.idx);
        end
        return gt;
    endfunction

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_COLLECT;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_COLLECT: if (w_accept && w_last_pix && w_last_img) w_state_nxt = S_SORT;
            S_SORT:    if (r_pass_cnt == LAST_IMG)               w_state_nxt = S_OUTPUT;
            S_OUTPUT:  if (w_done)                               w_state_nxt = S_COLLECT;
            default:                                             w_state_nxt = S_COLLECT;
        endcase
    end

    // Per-state control strobes
    always_comb begin
        w_accept    = 1'b0;
        w_sort_step = 1'b0;
        w_load      = 1'b0;
        w_hs        = 1'b0;
        case (r_state)
            S_COLLECT: w_accept    = in_valid & ~busy;
            S_SORT:    w_sort_step = 1'b1;
            S_OUTPUT: begin
                w_load = ~out_valid;
                w_hs   = out_valid & out_ready;
            end
            default: ;
        endcase
    end

    // Votes/sums including the current pixel; ties resolve R>G>B
    always_comb begin
        w_vote_r = r_vote_r;
        w_vote_g = r_vote_g;
        w_vote_b = r_vote_b;
        if (w_ch_r >= w_ch_g && w_ch_r >= w_ch_b) w_vote_r = r_vote_r + CNT_W'(1);
        else if (w_ch_g >= w_ch_b)                 w_vote_g = r_vote_g + CNT_W'(1);
        else                                       w_vote_b = r_vote_b + CNT_W'(1);
        w_sum_r = r_sum_r + KEY_W'(w_ch_r);
        w_sum_g = r_sum_g + KEY_W'(w_ch_g);
        w_sum_b = r_sum_b + KEY_W'(w_ch_b);
        w_entry.idx = image_in_index;
        if (w_vote_r >= w_vote_g && w_vote_r >= w_vote_b) begin
            w_entry.cls = 2'd0;
            w_entry.key = w_sum_r;
        end else if (w_vote_g >= w_vote_b) begin
            w_entry.cls = 2'd1;
            w_entry.key = w_sum_g;
        end else begin
            w_entry.cls = 2'd2;
            w_entry.key = w_sum_b;
        end
    end

    // One odd-even transposition pass; pass parity picks the pair alignment
    always_comb begin
        for (int i = 0; i < int'(IMAGE_NUM); i++) w_pass[i] = r_tbl[i];
        for (int i = 0; i < int'(IMAGE_NUM) - 1; i++) begin
            if (i[0] == r_pass_cnt[0] && entry_gt(r_tbl[i], r_tbl[i+1])) begin
                w_pass[i]   = r_tbl[i+1];
                w_pass[i+1] = r_tbl[i];
            end
        end
    end

    // Pixel accumulation and image counting
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pix_cnt <= '0;
            r_img_cnt <= '0;
            r_vote_r  <= '0;
            r_vote_g  <= '0;
            r_vote_b  <= '0;
            r_sum_r   <= '0;
            r_sum_g   <= '0;
            r_sum_b   <= '0;
        end else if (w_accept) begin
            if (w_last_pix) begin
                r_pix_cnt <= '0;
                r_img_cnt <= w_last_img ? '0 : r_img_cnt + IDX_W'(1);
                r_vote_r  <= '0;
                r_vote_g  <= '0;
                r_vote_b  <= '0;
                r_sum_r   <= '0;
                r_sum_g   <= '0;
                r_sum_b   <= '0;
            end else begin
                r_pix_cnt <= r_pix_cnt + CNT_W'(1);
                r_vote_r  <= w_vote_r;
                r_vote_g  <= w_vote_g;
                r_vote_b  <= w_vote_b;
                r_sum_r   <= w_sum_r;
                r_sum_g   <= w_sum_g;
                r_sum_b   <= w_sum_b;
            end
        end
    end

    // Entry table: filled in arrival order, sorted in place, cleared after output
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(IMAGE_NUM); i++) r_tbl[i] <= '0;
        end else if (w_done) begin
            for (int i = 0; i < int'(IMAGE_NUM); i++) r_tbl[i] <= '0;
        end else if (w_sort_step) begin
            for (int i = 0; i < int'(IMAGE_NUM); i++) r_tbl[i] <= w_pass[i];
        end else if (w_accept && w_last_pix) begin
            r_tbl[r_img_cnt] <= w_entry;
        end
    end

    // Sort pass counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)           r_pass_cnt <= '0;
        else if (w_sort_step) r_pass_cnt <= (r_pass_cnt == LAST_IMG) ? '0 : r_pass_cnt + IDX_W'(1);
    end

    // Registered outputs; the first OUTPUT cycle loads slot 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy            <= 1'b0;
            out_valid       <= 1'b0;
            color_index     <= 2'd0;
            image_out_index <= '0;
            r_out_ptr       <= '0;
        end else begin
            busy <= (w_state_nxt != S_COLLECT);
            if (w_load) begin
                out_valid       <= 1'b1;
                color_index     <= r_tbl[r_out_ptr].cls;
                image_out_index <= r_tbl[r_out_ptr].idx;
            end else if (w_done) begin
                out_valid <= 1'b0;
                r_out_ptr <= '0;
            end else if (w_hs) begin
                r_out_ptr       <= w_out_ptr_inc;
                color_index     <= r_tbl[w_out_ptr_inc].cls;
                image_out_index <= r_tbl[w_out_ptr_inc].idx;
            end
        end
    end

endmodule
